secuenciador_reset: RTL and testbench



---
 rtl/secuenciador_reset.sv | 155 +++++++++++++++
 tb/tb_secuenciador_reset.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_reset.sv
// Reset sequencer and clock-enable generator for the PLL clock domain.
// Qualifies PLL lock, holds the system in reset, then emits /2, /4, /8 enables.
module secuenciador_reset #(
    parameter int LOCK_STABLE = 256,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PLL_LOCK,
    output logic SYS_RESET,
    output logic READY,
    output logic CE_DIV2,
    output logic CE_DIV4,
    output logic CE_DIV8,
    output logic LOCK_LOST
);

    localparam int LW = $clog2(LOCK_STABLE) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic          sync_meta_r;
    logic          lock_sync_r;
    state_t        state_r;
    state_t        state_s;
    logic [LW-1:0] lock_cnt_r;
    logic [LW-1:0] lock_cnt_s;
    logic [HW-1:0] hold_cnt_r;
    logic [HW-1:0] hold_cnt_s;
    logic [2:0]    dcnt_r;
    logic [2:0]    dcnt_s;
    logic          lost_set_s;
    logic          run_next_s;
    logic          sys_reset_r;
    logic          ready_r;
    logic          ce_div2_r;
    logic          ce_div4_r;
    logic          ce_div8_r;
    logic          lock_lost_r;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            sync_meta_r <= PLL_LOCK;
            lock_sync_r <= sync_meta_r;
        end
    end

    // Next-state and counter logic of the sequencer.
    always_comb begin
        state_s    = state_r;
        lock_cnt_s = lock_cnt_r;
        hold_cnt_s = hold_cnt_r;
        lost_set_s = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                if (!lock_sync_r) begin
                    lock_cnt_s = '0;
                end else if (lock_cnt_r == LOCK_LAST) begin
                    state_s    = HOLD;
                    lock_cnt_s = '0;
                end else begin
                    lock_cnt_s = lock_cnt_r + LW'(1);
                end
            end
            HOLD: begin
                if (!lock_sync_r) begin
                    state_s    = WAIT_LOCK;
                    hold_cnt_s = '0;
                    lost_set_s = 1'b1;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = RUN;
                    hold_cnt_s = '0;
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end
            end
            RUN: begin
                if (!lock_sync_r) begin
                    state_s    = WAIT_LOCK;
                    lost_set_s = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s    = WAIT_LOCK;
                lock_cnt_s = '0;
                hold_cnt_s = '0;
            end
        endcase
    end

    // Divider phase: counts only while staying in RUN, zero otherwise.
    always_comb begin
        run_next_s = (state_s == RUN);
        if ((state_r == RUN) && run_next_s) begin
            dcnt_s = dcnt_r + 3'd1;
        end else begin
            dcnt_s = 3'd0;
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= WAIT_LOCK;
            lock_cnt_r <= '0;
            hold_cnt_r <= '0;
            dcnt_r     <= 3'd0;
        end else begin
            state_r    <= state_s;
            lock_cnt_r <= lock_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            dcnt_r     <= dcnt_s;
        end
    end

    // Outputs registered from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sys_reset_r <= 1'b1;
            ready_r     <= 1'b0;
            ce_div2_r   <= 1'b0;
            ce_div4_r   <= 1'b0;
            ce_div8_r   <= 1'b0;
            lock_lost_r <= 1'b0;
        end else begin
            sys_reset_r <= !run_next_s;
            ready_r     <= run_next_s;
            ce_div2_r   <= run_next_s & dcnt_s[0];
            ce_div4_r   <= run_next_s & (dcnt_s[1:0] == 2'd3);
            ce_div8_r   <= run_next_s & (dcnt_s == 3'd7);
            lock_lost_r <= lock_lost_r | lost_set_s;
        end
    end

    assign SYS_RESET = sys_reset_r;
    assign READY     = ready_r;
    assign CE_DIV2   = ce_div2_r;
    assign CE_DIV4   = ce_div4_r;
    assign CE_DIV8   = ce_div8_r;
    assign LOCK_LOST = lock_lost_r;

endmodule

// File: tb/tb_secuenciador_reset.sv
// Self-checking bench for secuenciador_reset: directed scenarios plus random lock
// patterns compared against a streak-count reference model.
module tb_secuenciador_reset;

    localparam int LS = 4;
    localparam int HS = 8;
    localparam int T  = LS + HS;

    logic CLK;
    logic RESET;
    logic PLL_LOCK;
    logic SYS_RESET;
    logic READY;
    logic CE_DIV2;
    logic CE_DIV4;
    logic CE_DIV8;
    logic LOCK_LOST;

    int checks   = 0;
    int failures = 0;

    // Reference model: n = consecutive clock edges that saw a synchronized high lock.
    int m_n;
    bit m_s1;
    bit m_s2;
    bit m_lost;

    secuenciador_reset #(
        .LOCK_STABLE(LS),
        .HOLD_CYCLES(HS)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PLL_LOCK (PLL_LOCK),
        .SYS_RESET(SYS_RESET),
        .READY    (READY),
        .CE_DIV2  (CE_DIV2),
        .CE_DIV4  (CE_DIV4),
        .CE_DIV8  (CE_DIV8),
        .LOCK_LOST(LOCK_LOST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [5:0] act_vec();
        return {SYS_RESET, READY, CE_DIV2, CE_DIV4, CE_DIV8, LOCK_LOST};
    endfunction

    function automatic logic [5:0] exp_vec();
        bit rdy;
        int d;
        rdy = (m_n >= T);
        d   = rdy ? ((m_n - T) % 8) : 0;
        return {!rdy, rdy, rdy && (d % 2 == 1), rdy && (d % 4 == 3), rdy && (d == 7), m_lost};
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        m_lost = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!m_s2) begin
            if (m_n >= LS) m_lost = 1'b1;
            m_n = 0;
        end else begin
            m_n = m_n + 1;
        end
        m_s2 = m_s1;
        m_s1 = PLL_LOCK;
        #1;
    endtask

    task automatic do_reset(input logic lock_level);
        RESET    = 1'b1;
        PLL_LOCK = lock_level;
        repeat (3) @(posedge CLK);
        #2;
        model_reset();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET    = 1'b1;
        PLL_LOCK = 1'b0;
        #1;
        checks++;
        if (act_vec() !== 6'b100000) begin
            failures++;
            $display("FAIL reset_assert got=%b exp=%b", act_vec(), 6'b100000);
        end
        do_reset(1'b0);
        checks++;
        if (act_vec() !== 6'b100000) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", act_vec(), 6'b100000);
        end
    endtask

    task automatic test_startup();
        do_reset(1'b1);
        for (int e = 1; e <= 14; e++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL startup_model edge=%0d got=%b exp=%b", e, act_vec(), exp_vec());
            end
            checks++;
            if (SYS_RESET !== (e < 14) || READY !== (e >= 14) || LOCK_LOST !== 1'b0) begin
                failures++;
                $display("FAIL startup_edge edge=%0d sys_reset=%b ready=%b lost=%b exp_sys_reset=%b",
                         e, SYS_RESET, READY, LOCK_LOST, (e < 14));
            end
        end
    endtask

    task automatic test_enables();
        int c2 = 0;
        int c4 = 0;
        int c8 = 0;
        logic p2 = CE_DIV2;
        logic p4 = CE_DIV4;
        logic p8 = CE_DIV8;
        for (int i = 0; i < 64; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL enables_model cyc=%0d got=%b exp=%b", i, act_vec(), exp_vec());
            end
            checks++;
            if ((CE_DIV8 && !(CE_DIV4 && CE_DIV2)) || (CE_DIV4 && !CE_DIV2) ||
                (CE_DIV2 && p2) || (CE_DIV4 && p4) || (CE_DIV8 && p8)) begin
                failures++;
                $display("FAIL enables_shape cyc=%0d ce2=%b ce4=%b ce8=%b prev=%b%b%b",
                         i, CE_DIV2, CE_DIV4, CE_DIV8, p2, p4, p8);
            end
            c2 += int'(CE_DIV2);
            c4 += int'(CE_DIV4);
            c8 += int'(CE_DIV8);
            p2 = CE_DIV2;
            p4 = CE_DIV4;
            p8 = CE_DIV8;
        end
        checks++;
        if (c2 != 32 || c4 != 16 || c8 != 8) begin
            failures++;
            $display("FAIL enables_count got=%0d/%0d/%0d exp=32/16/8", c2, c4, c8);
        end
    endtask

    // Waits up to a bound for READY after a lock rise and checks the exact edge.
    task automatic wait_run(input string name, input int exp_edge, input logic exp_lost);
        int got = -1;
        for (int e = 1; e <= exp_edge + 4; e++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL %s_model edge=%0d got=%b exp=%b", name, e, act_vec(), exp_vec());
            end
            if (READY === 1'b1 && got < 0) got = e;
        end
        checks++;
        if (got != exp_edge || LOCK_LOST !== exp_lost) begin
            failures++;
            $display("FAIL %s_run_edge got=%0d exp=%0d lost=%b exp_lost=%b",
                     name, got, exp_edge, LOCK_LOST, exp_lost);
        end
    endtask

    task automatic test_glitch();
        do_reset(1'b0);
        repeat (3) tick();
        PLL_LOCK = 1'b1;
        repeat (3) tick();
        PLL_LOCK = 1'b0;
        tick();
        PLL_LOCK = 1'b1;
        wait_run("glitch", 14, 1'b0);
    endtask

    task automatic test_lock_loss_run();
        PLL_LOCK = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec() || SYS_RESET !== (e >= 3) || LOCK_LOST !== (e >= 3) ||
                (e >= 3 && (CE_DIV2 || CE_DIV4 || CE_DIV8 || READY))) begin
                failures++;
                $display("FAIL runloss edge=%0d got=%b exp=%b", e, act_vec(), exp_vec());
            end
        end
        PLL_LOCK = 1'b1;
        wait_run("runloss_relock", 14, 1'b1);
    endtask

    task automatic test_lock_loss_hold();
        do_reset(1'b1);
        repeat (8) tick();
        PLL_LOCK = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec() || LOCK_LOST !== (e >= 3) || SYS_RESET !== 1'b1) begin
                failures++;
                $display("FAIL holdloss edge=%0d got=%b exp=%b", e, act_vec(), exp_vec());
            end
        end
        PLL_LOCK = 1'b1;
        wait_run("holdloss_relock", 14, 1'b1);
    endtask

    task automatic test_async_reset();
        repeat (5) tick();
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (act_vec() !== 6'b100000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", act_vec(), 6'b100000);
        end
        repeat (2) @(posedge CLK);
        #2;
        model_reset();
        RESET = 1'b0;
        wait_run("async_restart", 14, 1'b0);
    endtask

    task automatic test_random();
        int run_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run_left == 0) begin
                PLL_LOCK = ~PLL_LOCK;
                run_left = PLL_LOCK ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 6));
            end
            run_left--;
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        RESET    = 1'b1;
        PLL_LOCK = 1'b0;
        model_reset();
        test_reset();
        test_startup();
        test_enables();
        test_glitch();
        test_lock_loss_run();
        test_lock_loss_hold();
        test_async_reset();
        do_reset(1'b0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
